// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM main control unit for the multi-cycle RISC-V core
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALU_Control
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [1:0] alu_op;
    logic       branch;
    logic       pc_update;

    // State register; reset forces FETCH without waiting for a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; any unused encoding falls back to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore output decode: every select and enable depends on the state alone
    always_comb begin
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        alu_op    = 2'b00;
        branch    = 1'b0;
        pc_update = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            S_DECODE: begin
                // PC-relative target precomputed into ALUOut for a possible branch
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: begin
                alu_op = 2'b00;
            end
        endcase
    end

    // PC enable: unconditional update or taken branch; zero flows straight through
    always_comb begin
        PCWrite = pc_update | (branch & zero);
    end

    // ALU operation decode; subtract only for R-type with funct7[5] set
    always_comb begin
        ALU_Control = 3'b010;
        case (alu_op)
            2'b00: ALU_Control = 3'b010;
            2'b01: ALU_Control = 3'b011;
            default: begin
                case (funct3)
                    3'b000:  ALU_Control = (opcode[5] & funct7_5) ? 3'b011 : 3'b010;
                    3'b010:  ALU_Control = 3'b110;
                    3'b110:  ALU_Control = 3'b100;
                    3'b111:  ALU_Control = 3'b101;
                    default: ALU_Control = 3'b000;
                endcase
            end
        endcase
    end

    // Immediate format select straight from the opcode
    always_comb begin
        case (opcode)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic [2:0] ALU_Control;

    int checks;
    int failures;

    // Bench-side state labels
    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4,
                   MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9, JAL = 10;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ALU_Control(ALU_Control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Hand-written table {AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite}
    function automatic logic [9:0] exp_ctl(input int st);
        case (st)
            FETCH:    exp_ctl = 10'b0_0_1_10_00_10_0;
            DECODE:   exp_ctl = 10'b0_0_0_00_01_01_0;
            MEMADR:   exp_ctl = 10'b0_0_0_00_10_01_0;
            MEMREAD:  exp_ctl = 10'b1_0_0_00_00_00_0;
            MEMWB:    exp_ctl = 10'b0_0_0_01_00_00_1;
            MEMWRITE: exp_ctl = 10'b1_1_0_00_00_00_0;
            EXECR:    exp_ctl = 10'b0_0_0_00_10_00_0;
            EXECI:    exp_ctl = 10'b0_0_0_00_10_01_0;
            ALUWB:    exp_ctl = 10'b0_0_0_00_00_00_1;
            BEQ:      exp_ctl = 10'b0_0_0_00_10_00_0;
            JAL:      exp_ctl = 10'b0_0_0_00_01_10_0;
            default:  exp_ctl = 10'b0;
        endcase
    endfunction

    function automatic logic [9:0] got_ctl();
        got_ctl = {AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite};
    endfunction

    // Check the current cycle (sampled at negedge), then advance to the next negedge
    task automatic cyc(input string tag, input int st, input logic [2:0] alu, input logic pcw);
        check({tag, "_ctl"}, {6'd0, got_ctl()}, {6'd0, exp_ctl(st)});
        check({tag, "_alu"}, {13'd0, ALU_Control}, {13'd0, alu});
        check({tag, "_pcw"}, {15'd0, PCWrite}, {15'd0, pcw});
        @(negedge clk);
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    // R/I-type run: FETCH, DECODE, EXEC, ALUWB
    task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [2:0] alu_exp);
        set_ir(op, f3, f7);
        cyc({tag, "_fetch"}, FETCH, 3'b010, 1'b1);
        cyc({tag, "_decode"}, DECODE, 3'b010, 1'b0);
        cyc({tag, "_exec"}, (op == 7'b0110011) ? EXECR : EXECI, alu_exp, 1'b0);
        cyc({tag, "_wb"}, ALUWB, 3'b010, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        zero     = 1'b0;
        set_ir(7'b0000011, 3'b010, 1'b0);

        // Reset held across three clocks
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_irwrite", {15'd0, IRWrite}, 16'd1);
        check("rst_alusrcb", {14'd0, ALUSrcB}, 16'd2);
        check("rst_alu", {13'd0, ALU_Control}, 16'd2);
        rst_n = 1'b1;

        // lw
        cyc("lw_fetch", FETCH, 3'b010, 1'b1);
        cyc("lw_decode", DECODE, 3'b010, 1'b0);
        check("lw_immsrc", {14'd0, ImmSrc}, 16'd0);
        cyc("lw_memadr", MEMADR, 3'b010, 1'b0);
        cyc("lw_memread", MEMREAD, 3'b010, 1'b0);
        cyc("lw_memwb", MEMWB, 3'b010, 1'b0);

        // sw
        set_ir(7'b0100011, 3'b010, 1'b0);
        cyc("sw_fetch", FETCH, 3'b010, 1'b1);
        cyc("sw_decode", DECODE, 3'b010, 1'b0);
        check("sw_immsrc", {14'd0, ImmSrc}, 16'd1);
        cyc("sw_memadr", MEMADR, 3'b010, 1'b0);
        cyc("sw_memwrite", MEMWRITE, 3'b010, 1'b0);

        // ALU decode variants
        run_alu("sub",  7'b0110011, 3'b000, 1'b1, 3'b011);
        run_alu("add",  7'b0110011, 3'b000, 1'b0, 3'b010);
        run_alu("addi", 7'b0010011, 3'b000, 1'b1, 3'b010);
        run_alu("or",   7'b0110011, 3'b110, 1'b0, 3'b100);
        run_alu("and",  7'b0110011, 3'b111, 1'b0, 3'b101);
        run_alu("slt",  7'b0110011, 3'b010, 1'b0, 3'b110);
        run_alu("slli", 7'b0010011, 3'b001, 1'b0, 3'b000);

        // beq taken and not taken
        set_ir(7'b1100011, 3'b000, 1'b0);
        zero = 1'b1;
        cyc("beqt_fetch", FETCH, 3'b010, 1'b1);
        cyc("beqt_decode", DECODE, 3'b010, 1'b0);
        check("beqt_immsrc", {14'd0, ImmSrc}, 16'd2);
        cyc("beqt_beq", BEQ, 3'b011, 1'b1);
        zero = 1'b0;
        cyc("beqn_fetch", FETCH, 3'b010, 1'b1);
        cyc("beqn_decode", DECODE, 3'b010, 1'b0);
        cyc("beqn_beq", BEQ, 3'b011, 1'b0);

        // jal
        set_ir(7'b1101111, 3'b000, 1'b0);
        cyc("jal_fetch", FETCH, 3'b010, 1'b1);
        cyc("jal_decode", DECODE, 3'b010, 1'b0);
        check("jal_immsrc", {14'd0, ImmSrc}, 16'd3);
        cyc("jal_jal", JAL, 3'b010, 1'b1);
        cyc("jal_wb", ALUWB, 3'b010, 1'b0);

        // Unknown opcode: two cycles, no writes
        set_ir(7'b1111111, 3'b000, 1'b0);
        cyc("unk_fetch", FETCH, 3'b010, 1'b1);
        cyc("unk_decode", DECODE, 3'b010, 1'b0);

        // Reset during MEMREAD returns to FETCH without a clock edge
        set_ir(7'b0000011, 3'b010, 1'b0);
        cyc("rlw_fetch", FETCH, 3'b010, 1'b1);
        cyc("rlw_decode", DECODE, 3'b010, 1'b0);
        cyc("rlw_memadr", MEMADR, 3'b010, 1'b0);
        check("rlw_memread_ctl", {6'd0, got_ctl()}, {6'd0, exp_ctl(MEMREAD)});
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_ctl", {6'd0, got_ctl()}, {6'd0, exp_ctl(FETCH)});
        check("async_rst_pcw", {15'd0, PCWrite}, 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_rst_fetch", FETCH, 3'b010, 1'b1);
        cyc("post_rst_decode", DECODE, 3'b010, 1'b0);
        cyc("post_rst_memadr", MEMADR, 3'b010, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit for the multi-cycle RISC-V core variant. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback cycles, and drives every datapath select line. It generates `ALU_Control` in the 3-bit encoding the ALU consumes and takes the ALU's `zero` flag back to resolve branches. It sits between the instruction register and the shared datapath: one memory, one ALU, and the PC, OldPC, IR, Data and ALUOut registers.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  7  IR[6:0]
- `funct3`  in  3  IR[14:12]
- `funct7_5`  in  1  IR[30]
- `zero`  in  1  ALU zero flag (combinational from ALU_result)
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result
- `MemWrite`  out  1  data memory write enable
- `IRWrite`  out  1  IR/OldPC enable
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALU_result
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = RD1
- `ALUSrcB`  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- `RegWrite`  out  1  register file write enable
- `ImmSrc`  out  2  00 = I, 01 = S, 10 = B, 11 = J
- `ALU_Control`  out  3  010 add, 011 sub, 110 slt, 100 or, 101 and

## Operation
- State register resets asynchronously to FETCH.
- All outputs except `PCWrite`, `ALU_Control` and `ImmSrc` are decoded from the state only.
- `PCWrite` = PCUpdate | (Branch & zero).
- Default in every state: all enables 0, selects 00, ALUOp 00.
- States, their asserted signals and transitions:
  - FETCH: AdrSrc=0, IRWrite, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other opcode → FETCH, with no write of any kind.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if opcode[5]=0, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite. Next: FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite. Next: FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate. Next: ALUWB.
- ALU decode (combinational):
  - ALUOp 00 → 010.
  - ALUOp 01 → 011.
  - ALUOp 10 by funct3:
    - 000 → 011 if (opcode[5] & funct7_5), else 010
    - 010 → 110
    - 110 → 100
    - 111 → 101
    - other → 000 (ALU outputs 0).
- ImmSrc from opcode (combinational):
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - else → 00.
- Unreachable state encodings → FETCH on the next edge.

## Timing
- Cycles per instruction, counted FETCH through the last state:
  - lw: 5
  - sw, R-type, I-type, jal: 4
  - beq: 3
  - unknown opcode: 2
- The `zero` → `PCWrite` path is combinational in BEQ. The PC updates on the BEQ-closing edge only if `zero`=1.
- Values while `rst_n`=0: state = FETCH, so outputs show FETCH values. The datapath registers are held in reset by the same `rst_n`, so these values have no effect.
- First FETCH edge is the first rising `clk` after `rst_n` deasserts.
- Reset asserted mid-instruction: state returns to FETCH immediately, without waiting for a clock edge. No partial writeback completes after the reset edge.
- `opcode`/`funct` inputs are sampled from IR and are stable from DECODE onward. Changes to these inputs during FETCH must not affect the FETCH outputs.

## Test plan
- Reset: hold `rst_n`=0 and toggle `clk` ×3 → state FETCH, IRWrite=1, ALUSrcB=10, ALU_Control=010. Release → DECODE on the next edge.
- lw (opcode 0000011): observe the state sequence → FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. RegWrite=1 only in MEMWB, with ResultSrc=01. MemWrite never asserts.
- sw (0100011): → MemWrite=1 in exactly one cycle with AdrSrc=1. ImmSrc=01 in MEMADR. Sequence length 4.
- R-type sub (opcode 0110011, funct3 000, funct7_5=1) → ALU_Control=011 in EXECR. With funct7_5=0 → 010. I-type addi with funct7_5=1 → 010. funct3 110 → 100; funct3 111 → 101; funct3 010 → 110.
- beq with zero=1 → PCWrite=1 in BEQ, ALU_Control=011, ImmSrc=10. With zero=0 → PCWrite=0. Either way, next state FETCH.
- jal (1101111) → PCWrite=1 in JAL, then RegWrite=1 in ALUWB. Unknown opcode 1111111 → DECODE then FETCH, with RegWrite, MemWrite and PCWrite all 0 in DECODE. Asserting `rst_n`=0 mid-MEMREAD → state FETCH before the next edge.
